ram_bank: RTL and testbench
===========================

Name: ram_bank

Overview:
- Parametrised single-port word RAM with a req/gnt request interface, per-byte write strobes and configurable read latency.
- After every reset, a hardware sweep clears the whole array before any request is granted.
- Serves as the on-chip instruction/data memory behind the core's bus interface.
- Read data is registered (not combinational), so memory timing is decoupled from the requester.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- DEPTH, 4096, number of DW-bit words; power of two, at least 2.
- RD_LAT, 1, read latency in cycles from accept to rvalid_o; legal values 1 or 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_  in  1  reset, synchronous, active-low.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DW/8  byte write strobes; ignored on reads.
- addr_i  in  32  byte address; word index = addr_i[AW+1:2], where AW = clog2(DEPTH).
- data_i  in  DW  write data.
- gnt_o  out  1  ready to accept; request accepted when req_i && gnt_o at a rising edge.
- rvalid_o  out  1  one-cycle pulse marking valid read data.
- data_o  out  DW  read data.
- init_done_o  out  1  high once the clear sweep has finished.

Behaviour:
- Reset (rst_=0 sampled at a rising edge): state=INIT, clear counter=0, read pipeline flushed. Outputs: rvalid_o=0, data_o=0, init_done_o=0, gnt_o=0.
- FSM INIT: each cycle writes 0 to mem[cnt] and increments cnt. When cnt==DEPTH-1, that word is written and the next state is RUN. INIT lasts exactly DEPTH cycles; req_i is ignored throughout.
- FSM RUN: init_done_o=1. gnt_o=1 continuously, driven from registered state only (no combinational path from req_i). No transition out of RUN except via reset.
- Write accept: for every byte b with be_i[b]=1, mem[idx][8b+7:8b] <= data_i[8b+7:8b] at the accept edge. Bytes with be_i[b]=0 are unchanged. be_i=0 means no change. Writes produce no rvalid_o.
- Read accept: rvalid_o pulses RD_LAT cycles after the accept edge, with data_o = mem[idx] as of the accept edge.
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
  - Back-to-back reads sustain one per cycle; responses are returned in order.
- data_o holds its last read value until the next rvalid_o. It never changes on writes.
- Address: addr_i[1:0] is ignored. Without RAM_ERR_EN, addr_i[31:AW+2] is ignored and addresses alias modulo DEPTH words.
- Reset mid-operation: in-flight reads are discarded (no rvalid_o), a new sweep starts from word 0, and all prior contents are lost.
- No parity, no ECC, no multi-requester arbitration.

Optional Feature:
- Macro: RAM_ERR_EN.
- Defined:
  - Adds port err_o (out, 1, reset 0).
  - A request with addr_i[31:AW+2] != 0 is out of range.
  - Out-of-range write: memory is unmodified, and err_o pulses 1 cycle after accept.
  - Out-of-range read: rvalid_o and err_o pulse together at RD_LAT, with data_o = RAM_ERR_DATA (32'hDEAD_BEEF, zero-extended or truncated to DW).
- Undefined: no err_o port; out-of-range addresses alias as described above.

Decomposition:
- Package ram_pkg holds:
  - state enum {INIT, RUN};
  - RAM_ERR_DATA constant;
  - clog2 helper function;
  - legal-RD_LAT check constant.
- Sub-module ram_array: storage only, with byte-strobe write port plus one registered read port (1-cycle latency).
- ram_bank contains the FSM, the clear counter, an optional second output register for RD_LAT=2, rvalid tracking and the error logic.

Test Plan:
- DEPTH=16, RD_LAT=1, preload array with 0xFFFFFFFF, reset 1 cycle. Expect gnt_o=0 for 16 cycles and init_done_o=1 at cycle 16. Then read words 0..15: each returns 0 with rvalid_o 1 cycle after accept.
- Write 0x11223344 to addr 0x8 with be=4'b1111, then write 0xAABBCCDD with be=4'b0101, then read 0x8. Expect 0x11BB33DD; read accepted the edge after the write sees the new value.
- RD_LAT=2: issue 4 back-to-back reads to addr 0x0, 0x4, 0x8, 0xC. Expect 4 consecutive rvalid_o pulses starting 2 cycles after the first accept, in order; data_o holds between pulses.
- Assert rst_=0 for one cycle while 2 reads are in flight. Expect no rvalid_o afterward, data_o=0, and a new 16-cycle sweep.
- Without RAM_ERR_EN, DEPTH=16: write 0x5 to addr 0x40, read addr 0x0. Expect 0x5 (aliasing).
- With RAM_ERR_EN, DEPTH=16: write to addr 0x40, then read 0x40. Expect err_o pulse 1 cycle after the write with word 0 unchanged; the read returns data_o=0xDEADBEEF with err_o=1 and rvalid_o=1.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_bank memory slice.
package ram_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [31:0] RAM_ERR_DATA = 32'hDEAD_BEEF;

    // Supported read latencies, in cycles from accept to rvalid_o.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage with a byte-strobed write port and one registered read port (1-cycle latency).
module ram_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // No reset on the array itself; the owner clears it with a sweep.
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < DW/8; b++)
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_bank.sv
// Single-port word RAM with req/gnt, byte strobes, RD_LAT of 1 or 2 and a clear sweep after reset.
// Define RAM_ERR_EN to add err_o and out-of-range address detection.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DW     = 32,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [31:0]     addr_i,
    input  logic [DW-1:0]   data_i,
    output logic            gnt_o,
    output logic            rvalid_o,
    output logic [DW-1:0]   data_o,
`ifdef RAM_ERR_EN
    output logic            err_o,
`endif
    output logic            init_done_o
);

    localparam int AW = clog2(DEPTH);
    localparam bit RD_LAT_OK = (RD_LAT >= RD_LAT_MIN) && (RD_LAT <= RD_LAT_MAX);
    localparam logic [DW-1:0] ERR_DATA = DW'(RAM_ERR_DATA);

    if (!RD_LAT_OK) begin : g_bad_rd_lat
        $error("ram_bank: RD_LAT must be 1 or 2");
    end

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            acc, rd_acc, wr_acc, oor, sweeping;
    logic            arr_we;
    logic [DW/8-1:0] arr_be;
    logic [AW-1:0]   arr_addr;
    logic [DW-1:0]   arr_wdata, arr_rdata;
    logic            rv1, rd_err1, wr_err1, rd_err_out;
    logic [DW-1:0]   d1;

    assign acc    = req_i && gnt_o;
    assign rd_acc = acc && !we_i;
    assign wr_acc = acc && we_i;

`ifdef RAM_ERR_EN
    assign oor = (addr_i >> (AW + 2)) != 32'd0;
`else
    assign oor = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state       <= INIT;
            cnt         <= '0;
            gnt_o       <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state       <= RUN;
                        gnt_o       <= 1'b1;
                        init_done_o <= 1'b1;
                    end
                end
                RUN: begin
                end
                default: state <= INIT;
            endcase
        end
    end

    // The sweep owns the array port until RUN; requests cannot be granted meanwhile.
    assign sweeping  = (state == INIT);
    assign arr_we    = sweeping || (wr_acc && !oor);
    assign arr_be    = sweeping ? '1 : be_i;
    assign arr_addr  = sweeping ? cnt : addr_i[AW+1:2];
    assign arr_wdata = sweeping ? '0 : data_i;

    ram_array #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_array (
        .clk   (clk),
        .rst_  (rst_),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .re    (rd_acc),
        .rdata (arr_rdata)
    );

    // rd_err1 only moves on read accepts so d1 keeps holding the last read result.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            rv1     <= 1'b0;
            rd_err1 <= 1'b0;
            wr_err1 <= 1'b0;
        end else begin
            rv1     <= rd_acc;
            wr_err1 <= wr_acc && oor;
            if (rd_acc) rd_err1 <= oor;
        end
    end

    assign d1 = rd_err1 ? ERR_DATA : arr_rdata;

    if (RD_LAT == 2) begin : g_lat2
        logic          rv2, e2;
        logic [DW-1:0] d2;
        always_ff @(posedge clk) begin
            if (!rst_) begin
                rv2 <= 1'b0;
                e2  <= 1'b0;
                d2  <= '0;
            end else begin
                rv2 <= rv1;
                if (rv1) begin
                    d2 <= d1;
                    e2 <= rd_err1;
                end
            end
        end
        assign rvalid_o   = rv2;
        assign data_o     = d2;
        assign rd_err_out = e2;
    end else begin : g_lat1
        assign rvalid_o   = rv1;
        assign data_o     = d1;
        assign rd_err_out = rd_err1;
    end

`ifdef RAM_ERR_EN
    assign err_o = wr_err1 || (rvalid_o && rd_err_out);
`endif

    logic unused_bits;
    assign unused_bits = ^{addr_i, wr_err1, rd_err_out};

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank: RD_LAT=1 and RD_LAT=2 instances share stimulus, checked against an array/log model.
module tb_ram_bank;

    localparam int DEPTH = 16;
    localparam int NLOG  = 2048;
`ifdef RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] data_i = 32'h0;
    logic        gnt1, rv1, id1, gnt2, rv2, id2;
    logic [31:0] do1, do2;
    logic        err1, err2;

    always #5 clk = ~clk;

    ram_bank #(.DW(32), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_(rst_), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .data_i(data_i), .gnt_o(gnt1), .rvalid_o(rv1), .data_o(do1),
`ifdef RAM_ERR_EN
        .err_o(err1),
`endif
        .init_done_o(id1)
    );

    ram_bank #(.DW(32), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_(rst_), .req_i(req_i), .we_i(we_i), .be_i(be_i),
        .addr_i(addr_i), .data_i(data_i), .gnt_o(gnt2), .rvalid_o(rv2), .data_o(do2),
`ifdef RAM_ERR_EN
        .err_o(err2),
`endif
        .init_done_o(id2)
    );

`ifndef RAM_ERR_EN
    assign err1 = 1'b0;
    assign err2 = 1'b0;
`endif

    // Model: memory contents, remaining sweep cycles, and a per-edge log of accepted reads.
    logic [31:0] mm [DEPTH];
    int          init_left;
    int          t;
    int          last_rst;
    bit          rv_log   [NLOG];
    bit          rerr_log [NLOG];
    bit          werr_log [NLOG];
    logic [31:0] rd_log   [NLOG];
    logic [31:0] exp_d    [1:2];
    int          checks;
    int          errs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    task automatic step(input logic rv, input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] d);
        bit   acc, oor, v;
        int   idx, k;
        logic exp_err;
        logic [31:0] obs_rv, obs_d, obs_e, obs_g, obs_i;
        @(negedge clk);
        rst_ = rv; req_i = req; we_i = we; be_i = be; addr_i = addr; data_i = d;
        acc = rv && req && (init_left == 0);
        @(posedge clk);
        t++;
        rv_log[t] = 1'b0; rerr_log[t] = 1'b0; werr_log[t] = 1'b0; rd_log[t] = 32'h0;
        if (!rv) begin
            init_left = DEPTH;
            last_rst  = t;
            exp_d[1]  = 32'h0;
            exp_d[2]  = 32'h0;
            for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        end else if (init_left > 0) begin
            init_left--;
        end else if (acc) begin
            idx = int'((addr >> 2) % DEPTH);
            oor = ERR_EN && (addr >= 4 * DEPTH);
            if (we) begin
                werr_log[t] = oor;
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                rv_log[t]   = 1'b1;
                rerr_log[t] = oor;
                rd_log[t]   = oor ? 32'hDEAD_BEEF : mm[idx];
            end
        end
        #1;
        for (int L = 1; L <= 2; L++) begin
            k = t - L + 1;
            v = (k > last_rst) && rv_log[k];
            if (v) exp_d[L] = rd_log[k];
            exp_err = (v && rerr_log[k]) || werr_log[t];
            obs_g  = 32'(L == 1 ? gnt1 : gnt2);
            obs_i  = 32'(L == 1 ? id1 : id2);
            obs_rv = 32'(L == 1 ? rv1 : rv2);
            obs_d  = (L == 1) ? do1 : do2;
            obs_e  = 32'(L == 1 ? err1 : err2);
            chk($sformatf("gnt_lat%0d", L), obs_g, 32'(init_left == 0));
            chk($sformatf("init_done_lat%0d", L), obs_i, 32'(init_left == 0));
            chk($sformatf("rvalid_lat%0d", L), obs_rv, 32'(v));
            chk($sformatf("data_lat%0d", L), obs_d, exp_d[L]);
            if (ERR_EN) chk($sformatf("err_lat%0d", L), obs_e, 32'(exp_err));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b1, be, a, d);
    endtask

    initial begin
        logic [31:0] a;
        t = 0; last_rst = 0; init_left = DEPTH; checks = 0; errs = 0;
        exp_d[1] = 32'h0; exp_d[2] = 32'h0;
        for (int i = 0; i < NLOG; i++) begin
            rv_log[i] = 1'b0; rerr_log[i] = 1'b0; werr_log[i] = 1'b0; rd_log[i] = 32'h0;
        end
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;

        step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 4'hf, 32'h0, 32'h0);
        // Writes offered during the sweep must be ignored.
        for (int i = 0; i < DEPTH; i++) wr(32'(4 * i), 4'hf, 32'h1234_5678);
        for (int i = 0; i < DEPTH; i++) wr(32'(4 * i), 4'hf, 32'hFFFF_FFFF);
        rd(32'h0);
        rd(32'h4);
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(32'(4 * i));
        idle(2);

        wr(32'h8, 4'b1111, 32'h1122_3344);
        wr(32'h8, 4'b0101, 32'hAABB_CCDD);
        rd(32'h8);
        idle(1);
        chk("byte_strobe_merge", do1, 32'h11BB_33DD);
        wr(32'h8, 4'b0000, 32'h0);
        rd(32'hB);
        idle(2);

        wr(32'h0, 4'hf, 32'hA0A0_0000);
        wr(32'h4, 4'hf, 32'hA1A1_1111);
        wr(32'hC, 4'hf, 32'hA3A3_3333);
        rd(32'h0); rd(32'h4); rd(32'h8); rd(32'hC);
        idle(3);

        wr(32'h40, 4'hf, 32'h5);
        rd(32'h0);
        rd(32'h40);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000_0000;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), a, $urandom);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
